mp_ram_bypass: RTL and testbench

MP_RAM_BYPASS -- requirements
Module: mp_ram_bypass

---
 rtl/mp_ram_pkg.sv | 7 +
 rtl/mp_ram_rd_port.sv | 36 +++
 rtl/mp_ram_bypass.sv | 72 +++++++
 tb/tb_mp_ram_bypass.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/mp_ram_pkg.sv
// mp_ram_pkg: shared types and constants for the multi-port bypass RAM
package mp_ram_pkg;
  typedef enum logic {INIT, RUN} state_t;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;
  localparam int COLL_W = 16;
endpackage

// File: rtl/mp_ram_rd_port.sv
// mp_ram_rd_port: read capture with write-collision merge, latency pipeline and output hold
module mp_ram_rd_port import mp_ram_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  input  logic                  rd,
  input  logic                  coll,
  input  logic [DATA_WIDTH-1:0] mem_q,
  input  logic [DATA_WIDTH-1:0] db,
  input  logic [DATA_WIDTH-1:0] bwb,
  output logic [DATA_WIDTH-1:0] q
);
  logic [DATA_WIDTH-1:0] merged;
  assign merged = coll ? (mem_q & ~bwb) | (db & bwb) : mem_q;
  if (RD_LATENCY == RD_LAT_MIN) begin : g_lat1
    always_ff @(posedge CLK or negedge rst_n)
      if (!rst_n) q <= '0;
      else if (rd) q <= merged;
  end else begin : g_lat2
    logic [DATA_WIDTH-1:0] d1;
    logic                  v1;
    // data is frozen at read time, so a write on the following edge cannot leak in
    always_ff @(posedge CLK or negedge rst_n)
      if (!rst_n) begin
        d1 <= '0;
        v1 <= 1'b0;
        q  <= '0;
      end else begin
        v1 <= rd;
        if (rd) d1 <= merged;
        if (v1) q <= d1;
      end
  end
endmodule

// File: rtl/mp_ram_bypass.sv
// mp_ram_bypass: 1W/NR RAM with write-through collision merge, optional zero-init sweep and collision counter
module mp_ram_bypass import mp_ram_pkg::*; #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RD     = 2,
  parameter int RD_LATENCY = 1,
  parameter int INIT_ZERO  = 1
) (
  input  logic                         CLK,
  input  logic                         rst_n,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] AA,
  input  logic [NUM_RD-1:0]            CEA,
  output logic [NUM_RD*DATA_WIDTH-1:0] QA,
  input  logic [ADDR_WIDTH-1:0]        AB,
  input  logic                         CEB,
  input  logic [DATA_WIDTH-1:0]        DB,
  input  logic [DATA_WIDTH-1:0]        BWB,
  output logic                         init_done,
  output logic [COLL_W-1:0]            coll_cnt
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  if (RD_LATENCY < RD_LAT_MIN || RD_LATENCY > RD_LAT_MAX || NUM_RD < 1 || NUM_RD > 4 ||
      INIT_ZERO < 0 || INIT_ZERO > 1) begin : g_bad_param
    $fatal(1, "mp_ram_bypass: illegal parameter combination");
  end
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] ptr;
  logic                  wr;
  logic [NUM_RD-1:0]     rd, coll;
  logic [2:0]            n_coll;
  logic [COLL_W:0]       coll_sum;
  assign init_done = state == RUN;
  assign wr        = CEB && init_done;
  assign state_nx  = (state == INIT && &ptr) ? RUN : state;
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) begin
      state <= INIT_ZERO != 0 ? INIT : RUN;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      if (state == INIT) ptr <= ptr + 1'b1;
    end
  // storage is deliberately not reset; only the init sweep clears it
  always_ff @(posedge CLK)
    if (state == INIT) mem[ptr] <= '0;
    else if (wr) mem[AB] <= (mem[AB] & ~BWB) | (DB & BWB);
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] a;
    assign a       = AA[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign rd[i]   = CEA[i] && init_done;
    assign coll[i] = rd[i] && wr && a == AB;
    mp_ram_rd_port #(.DATA_WIDTH(DATA_WIDTH), .RD_LATENCY(RD_LATENCY)) u_port (
      .CLK   (CLK),
      .rst_n (rst_n),
      .rd    (rd[i]),
      .coll  (coll[i]),
      .mem_q (mem[a]),
      .db    (DB),
      .bwb   (BWB),
      .q     (QA[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end
  always_comb begin
    n_coll = '0;
    for (int k = 0; k < NUM_RD; k++) n_coll = n_coll + {2'b0, coll[k]};
  end
  assign coll_sum = {1'b0, coll_cnt} + (COLL_W + 1)'(n_coll);
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) coll_cnt <= '0;
    else coll_cnt <= coll_sum[COLL_W] ? '1 : coll_sum[COLL_W-1:0];
endmodule

// File: tb/tb_mp_ram_bypass.sv
// tb_mp_ram_bypass: directed stimulus checked against a behavioural RAM model every cycle
module tb_mp_ram_bypass;
  localparam int LAT = 2;
  typedef struct {int due; int port; logic [31:0] val;} pend_t;
  logic        CLK = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] AA = '0;
  logic [1:0]  CEA = '0;
  logic [63:0] QA;
  logic [5:0]  AB = '0;
  logic        CEB = 1'b0;
  logic [31:0] DB = '0;
  logic [31:0] BWB = '0;
  logic        init_done;
  logic [15:0] coll_cnt;
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] m [64];
  logic [31:0] exq [2];
  int edges = 0;
  int cyc = 0;
  int ecnt = 0;
  pend_t pq[$];

  mp_ram_bypass #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .NUM_RD(2), .RD_LATENCY(LAT), .INIT_ZERO(1)) dut (
    .CLK(CLK), .rst_n(rst_n), .AA(AA), .CEA(CEA), .QA(QA), .AB(AB), .CEB(CEB),
    .DB(DB), .BWB(BWB), .init_done(init_done), .coll_cnt(coll_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic [1:0] cea, input logic [5:0] a0, input logic [5:0] a1,
                      input logic ceb, input logic [5:0] ab, input logic [31:0] db, input logic [31:0] bwb);
    CEA = cea; AA = {a1, a0}; CEB = ceb; AB = ab; DB = db; BWB = bwb;
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(2'b00, 6'd0, 6'd0, 1'b0, 6'd0, 32'h0, 32'h0);
  endtask

  // model: memory is zero once 64 clearing edges have passed; reads return old data merged with a same-edge write
  initial begin
    int c;
    logic [5:0] a;
    logic [31:0] v;
    pend_t keep[$];
    forever begin
      @(posedge CLK or negedge rst_n);
      if (!rst_n) begin
        edges = 0; cyc = 0; ecnt = 0; pq.delete(); exq[0] = 0; exq[1] = 0;
      end else begin
        cyc++;
        if (edges < 64) begin
          edges++;
          if (edges == 64) foreach (m[k]) m[k] = 32'h0;
        end else begin
          c = 0;
          for (int p = 0; p < 2; p++) if (CEA[p]) begin
            a = AA[p*6 +: 6];
            v = m[a];
            if (CEB && a == AB) begin
              v = (v & ~BWB) | (DB & BWB);
              c++;
            end
            pq.push_back('{cyc + LAT - 1, p, v});
          end
          ecnt = (ecnt + c > 65535) ? 65535 : ecnt + c;
          if (CEB) m[AB] = (m[AB] & ~BWB) | (DB & BWB);
        end
        keep.delete();
        foreach (pq[k]) if (pq[k].due == cyc) exq[pq[k].port] = pq[k].val; else keep.push_back(pq[k]);
        pq = keep;
      end
    end
  end

  initial forever begin
    @(negedge CLK);
    chk("init_done", {31'b0, init_done}, {31'b0, edges >= 64});
    chk("coll_cnt", {16'b0, coll_cnt}, ecnt);
    chk("qa0", QA[31:0], exq[0]);
    chk("qa1", QA[63:32], exq[1]);
  end

  initial begin
    repeat (2) @(negedge CLK);
    rst_n = 1'b1;
    repeat (63) @(negedge CLK);
    chk("init_low_at_63", {31'b0, init_done}, 32'd0);
    @(negedge CLK);
    chk("init_high_at_64", {31'b0, init_done}, 32'd1);
    for (int a = 0; a < 64; a++) step(2'b11, 6'(a), 6'(63 - a), 1'b0, 6'd0, 32'h0, 32'h0);
    idle(2);
    chk("zero_after_init", QA[31:0] | QA[63:32], 32'h0);
    step(2'b00, 6'd0, 6'd0, 1'b1, 6'd5, 32'hDEADBEEF, 32'hFFFFFFFF);
    step(2'b01, 6'd5, 6'd0, 1'b0, 6'd0, 32'h0, 32'h0);
    idle(1);
    chk("read_deadbeef", QA[31:0], 32'hDEADBEEF);
    step(2'b00, 6'd0, 6'd0, 1'b1, 6'd7, 32'h11111111, 32'hFFFFFFFF);
    step(2'b01, 6'd7, 6'd0, 1'b1, 6'd7, 32'hFFFFFFFF, 32'h0000FFFF);
    idle(1);
    chk("coll_merge", QA[31:0], 32'h1111FFFF);
    chk("coll_cnt_one", {16'b0, coll_cnt}, 32'd1);
    step(2'b00, 6'd0, 6'd0, 1'b1, 6'd3, 32'hA, 32'hFFFFFFFF);
    step(2'b01, 6'd3, 6'd0, 1'b0, 6'd0, 32'h0, 32'h0);
    step(2'b00, 6'd0, 6'd0, 1'b1, 6'd3, 32'hB, 32'hFFFFFFFF);
    chk("read_time_a", QA[31:0], 32'hA);
    step(2'b01, 6'd3, 6'd0, 1'b0, 6'd0, 32'h0, 32'h0);
    idle(1);
    chk("later_read_b", QA[31:0], 32'hB);
    idle(3);
    chk("hold_b", QA[31:0], 32'hB);
    step(2'b00, 6'd0, 6'd0, 1'b1, 6'd9, 32'h12345678, 32'hFFFFFFFF);
    step(2'b11, 6'd9, 6'd9, 1'b1, 6'd9, 32'hCAFEF00D, 32'hFF00FF00);
    idle(1);
    chk("dual_coll_p0", QA[31:0], 32'hCA34F078);
    chk("dual_coll_p1", QA[63:32], 32'hCA34F078);
    chk("coll_cnt_three", {16'b0, coll_cnt}, 32'd3);
    for (int k = 0; k < 32800; k++) step(2'b11, 6'd0, 6'd0, 1'b1, 6'd0, $urandom, 32'hFFFFFFFF);
    idle(1);
    chk("coll_cnt_sat", {16'b0, coll_cnt}, 32'h0000FFFF);
    step(2'b01, 6'd0, 6'd0, 1'b1, 6'd0, 32'h5, 32'hFFFFFFFF);
    chk("coll_cnt_sat_hold", {16'b0, coll_cnt}, 32'h0000FFFF);
    idle(2);
    #2 rst_n = 1'b0;
    @(negedge CLK);
    #2 rst_n = 1'b1;
    repeat (20) @(negedge CLK);
    #2 rst_n = 1'b0;
    @(negedge CLK);
    chk("mid_init_reset_low", {31'b0, init_done}, 32'd0);
    #2 rst_n = 1'b1;
    CEA = 2'b11; AA = {6'd9, 6'd9}; CEB = 1'b1; AB = 6'd9; DB = 32'hFFFFFFFF; BWB = 32'hFFFFFFFF;
    repeat (63) @(negedge CLK);
    chk("restart_low_at_63", {31'b0, init_done}, 32'd0);
    CEA = 2'b00; CEB = 1'b0;
    @(negedge CLK);
    chk("restart_high_at_64", {31'b0, init_done}, 32'd1);
    step(2'b01, 6'd9, 6'd0, 1'b0, 6'd0, 32'h0, 32'h0);
    idle(2);
    chk("cleared_after_restart", QA[31:0], 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
